// File: rtl/vram_pkg.sv
// Shared opcodes, region prefixes and engine state for the VRAM command front end.
package vram_pkg;

  // CPU command opcodes (in[23:16])
  localparam logic [7:0] OP_NTEX  = 8'd6;
  localparam logic [7:0] OP_YLINE = 8'd7;
  localparam logic [7:0] OP_TEXHI = 8'd8;
  localparam logic [7:0] OP_TEXLO = 8'd9;
  localparam logic [7:0] OP_CURX  = 8'd10;
  localparam logic [7:0] OP_CURY  = 8'd11;
  localparam logic [7:0] OP_TILE  = 8'd12;
  localparam logic [7:0] OP_PAL   = 8'd13;
  localparam logic [7:0] OP_UI    = 8'd14;
  localparam logic [7:0] OP_FILL  = 8'd15;
  localparam logic [7:0] OP_FDIM  = 8'd16;
  localparam logic [7:0] OP_CLM   = 8'd250;

  // Address-space region prefixes
  localparam logic [1:0] REG_TEX = 2'b01;
  localparam logic [1:0] REG_MAP = 2'b10;
  localparam logic [2:0] REG_PAL = 3'b111;
  localparam logic [2:0] REG_UI  = 3'b110;

  // Fill dimension / counter width
  localparam int unsigned FILL_W = 8;

  typedef enum logic {IDLE, FILL} state_t;

endpackage

// File: rtl/vram_fill_walker.sv
// Row-major rectangle walker: produces the wrapped tile-map address for each fill step.
module vram_fill_walker
  import vram_pkg::*;
#(
  parameter int unsigned TX_BITS = 6,
  parameter int unsigned TY_BITS = 5,
  parameter int unsigned ADDR_W  = TX_BITS + TY_BITS + 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [TX_BITS-1:0]  cx,
  input  logic [TY_BITS-1:0]  cy,
  input  logic [FILL_W-1:0]   fw,
  input  logic [FILL_W-1:0]   fh,
  output logic [ADDR_W-1:0]   addr_c,
  output logic                done_c
);

  logic [FILL_W-1:0]  i;
  logic [FILL_W-1:0]  j;
  logic [TX_BITS-1:0] x;
  logic [TY_BITS-1:0] y;

  // Current tile address (wraps at the map edges) and last-element flag
  always_comb begin
    x      = cx + TX_BITS'(i);
    y      = cy + TY_BITS'(j);
    addr_c = {REG_MAP, x, y};
    done_c = (i == fw - FILL_W'(1)) && (j == fh - FILL_W'(1));
  end

  // Step i inner / j outer while walking; counters sit at zero otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i <= '0;
      j <= '0;
    end else if (!en) begin
      i <= '0;
      j <= '0;
    end else if (i == fw - FILL_W'(1)) begin
      i <= '0;
      j <= j + FILL_W'(1);
    end else begin
      i <= i + FILL_W'(1);
    end
  end

endmodule

// File: rtl/vram_cmd_engine.sv
// VRAM command front end: decodes CPU commands into byte/nibble port writes and runs rectangle fills.
// Address layout assumes TEX_BITS+4 == TX_BITS+TY_BITS and ADDR_W == TX_BITS+TY_BITS+2.
module vram_cmd_engine
  import vram_pkg::*;
#(
  parameter int unsigned TEX_BITS = 7,
  parameter int unsigned TX_BITS  = 6,
  parameter int unsigned TY_BITS  = 5,
  parameter int unsigned PAL_BITS = 4,
  parameter int unsigned ADDR_W   = TX_BITS + TY_BITS + 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [23:0]         in,
  output logic                ready,
  output logic                err,
  output logic [ADDR_W-1:0]   waddr,
  output logic                w,
  output logic [7:0]          save1,
  output logic                ws,
  output logic                sel,
  output logic [PAL_BITS-1:0] save2
);

  state_t               state;
  logic [TEX_BITS-1:0]  ntex;
  logic [2:0]           yline;
  logic [TX_BITS-1:0]   cx;
  logic [TY_BITS-1:0]   cy;
  logic [FILL_W-1:0]    fw;
  logic [FILL_W-1:0]    fh;
  logic [7:0]           fill_val;
  logic [7:0]           op;
  logic [ADDR_W-1:0]    walk_addr_c;
  logic                 walk_done_c;

  assign op = in[23:16];

  vram_fill_walker #(
    .TX_BITS (TX_BITS),
    .TY_BITS (TY_BITS),
    .ADDR_W  (ADDR_W)
  ) u_walker (
    .clk    (clk),
    .rst    (rst),
    .en     (state == FILL),
    .cx     (cx),
    .cy     (cy),
    .fw     (fw),
    .fh     (fh),
    .addr_c (walk_addr_c),
    .done_c (walk_done_c)
  );

  // Engine FSM: command decode in IDLE, one tile write per cycle in FILL; all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ready    <= 1'b1;
      err      <= 1'b0;
      waddr    <= '0;
      w        <= 1'b0;
      save1    <= '0;
      ws       <= 1'b0;
      sel      <= 1'b0;
      save2    <= '0;
      ntex     <= '0;
      yline    <= '0;
      cx       <= '0;
      cy       <= '0;
      fw       <= '0;
      fh       <= '0;
      fill_val <= '0;
    end else begin
      err   <= 1'b0;
      waddr <= '0;
      w     <= 1'b0;
      save1 <= '0;
      ws    <= 1'b0;
      sel   <= 1'b0;
      save2 <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_NTEX:  ntex  <= in[TEX_BITS-1:0];
              OP_YLINE: yline <= in[2:0];
              OP_TEXHI: begin
                w     <= 1'b1;
                waddr <= {REG_TEX, ntex, yline, 1'b0};
                save1 <= in[15:8];
              end
              OP_TEXLO: begin
                w     <= 1'b1;
                waddr <= {REG_TEX, ntex, yline, 1'b1};
                save1 <= in[7:0];
                // yline carries into ntex on 7->0
                {ntex, yline} <= {ntex, yline} + (TEX_BITS + 3)'(1);
              end
              OP_CURX: cx <= in[TX_BITS+2:3];
              OP_CURY: cy <= in[TY_BITS+2:3];
              OP_TILE: begin
                w     <= 1'b1;
                waddr <= {REG_MAP, cx, cy};
                save1 <= in[7:0];
                // cx carries into cy on wrap
                {cy, cx} <= {cy, cx} + (TX_BITS + TY_BITS)'(1);
              end
              OP_PAL: begin
                ws    <= 1'b1;
                sel   <= ~cy[0];
                waddr <= {REG_PAL, cx, cy[TY_BITS-1:1]};
                save2 <= in[PAL_BITS-1:0];
              end
              OP_UI: begin
                ws    <= 1'b1;
                sel   <= ~cy[0];
                waddr <= {REG_UI, cx, cy[TY_BITS-1:1]};
                save2 <= in[PAL_BITS-1:0];
              end
              OP_FDIM: begin
                fw <= in[15:8];
                fh <= in[7:0];
              end
              OP_FILL: begin
                if (fw != '0 && fh != '0) begin
                  state    <= FILL;
                  ready    <= 1'b0;
                  fill_val <= in[7:0];
                end
              end
              OP_CLM: begin
                w     <= 1'b1;
                waddr <= in[ADDR_W-1:0];
                save1 <= '0;
              end
              default: ;
            endcase
          end
        end
        FILL: begin
          w     <= 1'b1;
          waddr <= walk_addr_c;
          save1 <= fill_val;
          err   <= start;
          if (walk_done_c) begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/vram_cmd_engine.md
Name: vram_cmd_engine

Overview:
- Parametrised VRAM command front end for the GRAPHICS subsystem.
- Decodes 24-bit CPU commands into the byte port (texture lines, tile map, raw writes) and the nibble port (palette/UI planes).
- New relative to the previous controller: registered outputs, auto-increment cursors, and a rectangle fill engine that bursts writes while busy, with a ready handshake.

Parameters:
- TEX_BITS, 7, log2 of texture count
- TX_BITS, 6, tile-map X width in tiles
- TY_BITS, 5, tile-map Y width in tiles (must be at least 2)
- PAL_BITS, 4, nibble-plane data width
- ADDR_W, TX_BITS+TY_BITS+2, VRAM address width. Legal only if TEX_BITS+4 equals TX_BITS+TY_BITS.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  command strobe
- in  in  24  command: opcode in[23:16], operand in[15:0]
- ready  out  1  engine can accept a command this cycle
- err  out  1  one-cycle pulse: start arrived while not ready
- waddr  out  ADDR_W  write address (shared by both ports)
- w  out  1  byte-port write strobe
- save1  out  8  byte-port data
- ws  out  1  nibble-port write strobe
- sel  out  1  nibble half-select
- save2  out  PAL_BITS  nibble-port data

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. All outputs reset to 0 except ready=1. ntex, yline, cursor (cx,cy) and fill dims (fw,fh) reset to 0. State resets to IDLE.
- States: IDLE and FILL. ready = (state==IDLE).
- Command acceptance: a command is accepted when start && ready.
- Rejected commands: start && !ready drops the command, pulses err next cycle, and changes no state.
- Latency: every output strobe is registered and appears exactly 1 cycle after acceptance. Strobes are single-cycle.
- Data outputs: waddr, save1 and save2 are 0 whenever no strobe is active.
- Opcodes (decimal):
  - 6: ntex <= in[TEX_BITS-1:0]
  - 7: yline <= in[2:0]
  - 8: w=1; waddr={2'b01,ntex,yline,1'b0}; save1=in[15:8]
  - 9: w=1; waddr={2'b01,ntex,yline,1'b1}; save1=in[7:0]. Then yline+1. On wrap 7->0, ntex+1 (ntex wraps modulo 2^TEX_BITS).
  - 10: cx <= in[TX_BITS+2:3] (pixel to tile)
  - 11: cy <= in[TY_BITS+2:3]
  - 12: w=1; waddr={2'b10,cx,cy}; save1=in[7:0]. Then cx+1. On cx wrap to 0, cy+1 (cy wraps modulo 2^TY_BITS).
  - 13: ws=1; sel=~cy[0]; waddr={3'b111,cx,cy[TY_BITS-1:1]}; save2=in[PAL_BITS-1:0]. Cursor unchanged.
  - 14: same as 13 but with prefix 3'b110 (UI plane).
  - 16: fw <= in[15:8]; fh <= in[7:0]
  - 15: fill start, value v=in[7:0]. If fw==0 or fh==0: no-op, stays IDLE, ready stays high. Otherwise enter FILL.
  - 250: w=1; waddr=in[ADDR_W-1:0]; save1=0 (clear-memory write).
  - Any other opcode: ignored, no err.
- FILL:
  - One tile-map write per cycle, row-major from (cx,cy): i = 0..fw-1 inner, j = 0..fh-1 outer.
  - Address is {2'b10,(cx+i) mod 2^TX_BITS,(cy+j) mod 2^TY_BITS}; save1=v.
  - State is FILL for exactly fw*fh cycles, then returns to IDLE.
  - Cursor is not modified by a fill.
- Fill timing: fill accepted at cycle N gives ready=0 for cycles N+1..N+fw*fh and writes at N+2..N+fw*fh+1. ready returns to 1 at N+fw*fh+1, so a command can be accepted that cycle.
- Reset mid-fill: aborts immediately; no further strobes.
- Counter widths: fill counters are 8 bits. fw and fh above the map size simply wrap and rewrite tiles.

Decomposition:
- Package vram_pkg holds:
  - opcode localparams: OP_NTEX=6, OP_YLINE=7, OP_TEXHI=8, OP_TEXLO=9, OP_CURX=10, OP_CURY=11, OP_TILE=12, OP_PAL=13, OP_UI=14, OP_FILL=15, OP_FDIM=16, OP_CLM=250
  - region prefixes REG_TEX=2'b01, REG_MAP=2'b10, REG_PAL=3'b111, REG_UI=3'b110
  - state enum {IDLE, FILL}
- One natural sub-module: vram_fill_walker. It owns the i/j counters and the wrapped address, and raises a done flag.

Test Plan:
- Texture write: ntex=5, yline=2, then in=0x08AB00 -> next cycle w=1, waddr=0x0854, save1=0xAB. Then in=0x0900CD -> waddr=0x0855, save1=0xCD. Next opcode 8 uses yline=3.
- Texture wrap: ntex=127, yline=7, opcode 9 -> following opcode 8 hits waddr with ntex=0, yline=0, i.e. 0x0800.
- Tile and palette: in=0x0A01F8 (cx=63), in=0x0B0020 (cy=4), in=0x0C0055 -> w=1, waddr=0x17E4, save1=0x55, cursor becomes (0,5). Then cx=3 and opcode 13 with in[3:0]=0xA -> ws=1, sel=0, waddr=0x1C32, save2=0xA.
- Fill with edge wrap: cursor (62,31), in=0x100302, in=0x0F0011 -> ready low 6 cycles. Six writes of 0x11 at tiles (62,31), (63,31), (0,31), (62,0), (63,0), (0,0). A start mid-fill -> err pulse and no extra write.
- Zero dims: fw=0, opcode 15 -> no strobes, ready stays 1.
- Reset mid-fill: rst asserted after 2 writes -> outputs 0 immediately, ready=1 after release, cursor back to (0,0).
